seq_alu: RTL and testbench

- Parametrised, registered successor to the 4-bit combinational ALU.
- Operand width is WIDTH bits, with a valid/ready handshake on input and output, and status flags.
- Adds signed set-less-than, plus an optional iterative multi-cycle multiply.
- Sits between the register-file read stage and write-back of the lab datapath.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_arith.sv | 24 ++
 rtl/seq_alu.sv | 183 ++++++++++++++++++
 tb/tb_seq_alu.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu: op codes and the FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arith.sv
// Combinational add/subtract for seq_alu. The adder is WIDTH+1 bits wide so
// the carry lands in the top bit. When sub_i is set, b is inverted and the
// carry-in is 1, so a - b is computed as a + ~b + 1.
module alu_arith #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;

    // Invert b for subtract, add with carry-in, and derive signed overflow
    always_comb begin
        b_eff           = sub_i ? ~b_i : b_i;
        {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
        ovf_o           = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready handshake on both sides.
// Optional iterative shift-add multiply is enabled by the SEQ_ALU_MUL_EN macro;
// without it, op 110 is reported as an error like the reserved op 101.
//
// Handshake: an op is accepted on a rising edge where in_valid && in_ready;
// a, b and op are sampled at that edge. A result is consumed on a rising edge
// where out_valid && out_ready. In DONE with out_ready high, in_ready is also
// high, so a drain and a new accept may share one edge (1 op/cycle).
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             cout,
    output logic             ovf,
    output logic             err,
    output logic [1:0]       dbg_state
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d, err_q, err_d;

    logic [WIDTH-1:0] sum;
    logic             add_cout, add_ovf, sub_en, accept;
    logic [WIDTH-1:0] res_z;
    logic             res_cout, res_ovf, res_err;

`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // slt reuses the subtractor: the sign of a - b corrected by overflow
    assign sub_en = (op == OP_SUB) || (op == OP_SLT);

    alu_arith #(.WIDTH(WIDTH)) u_arith (
        .a_i    (a),
        .b_i    (b),
        .sub_i  (sub_en),
        .sum_o  (sum),
        .cout_o (add_cout),
        .ovf_o  (add_ovf)
    );

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign z         = z_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
    assign dbg_state = state_q;

    // Single-cycle result for the op currently presented on the inputs
    always_comb begin
        res_z    = '0;
        res_cout = 1'b0;
        res_ovf  = 1'b0;
        res_err  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res_z    = sum;
                res_cout = add_cout;
                res_ovf  = add_ovf;
            end
            OP_AND:  res_z = a & b;
            OP_OR:   res_z = a | b;
            OP_XOR:  res_z = a ^ b;
            OP_SLT:  res_z = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            // With multiply enabled this op is routed to BUSY before this
            // result is used, so flagging it here only matters when disabled.
            OP_MUL:  res_err = 1'b1;
            default: res_err = 1'b1;
        endcase
    end

    // Next-state and output-register logic for IDLE/BUSY/DONE
    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
`ifdef SEQ_ALU_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
`endif
        if ((state_q == ST_DONE) && out_ready && !accept) begin
            state_d = ST_IDLE;
        end
`ifdef SEQ_ALU_MUL_EN
        if (state_q == ST_BUSY) begin
            if (cnt_q == CNT_W'(WIDTH)) begin
                state_d = ST_DONE;
                z_d     = acc_q;
                zero_d  = (acc_q == '0);
                cout_d  = 1'b0;
                ovf_d   = 1'b0;
                err_d   = 1'b0;
            end else begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
            end
        end
`endif
        if (accept) begin
`ifdef SEQ_ALU_MUL_EN
            if (op == OP_MUL) begin
                state_d  = ST_BUSY;
                acc_d    = '0;
                mcand_d  = a;
                mplier_d = b;
                cnt_d    = '0;
            end else begin
                state_d = ST_DONE;
                z_d     = res_z;
                zero_d  = (res_z == '0);
                cout_d  = res_cout;
                ovf_d   = res_ovf;
                err_d   = res_err;
            end
`else
            state_d = ST_DONE;
            z_d     = res_z;
            zero_d  = (res_z == '0);
            cout_d  = res_cout;
            ovf_d   = res_ovf;
            err_d   = res_err;
`endif
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            z_q      <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            z_q      <= z_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
`ifdef SEQ_ALU_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu at WIDTH = 8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         zero;
    logic         cout;
    logic         ovf;
    logic         err;
    logic [1:0]   dbg_state;

    int passed = 0;
    int total  = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .zero      (zero),
        .cout      (cout),
        .ovf       (ovf),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // present one op and step past its accept edge (DUT must be ready)
    task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
        op       = o;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = 3'b000;
        step(); step();
        rst_n = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if ({z, zero, cout, ovf, err} !== 12'h000) $display("FAIL reset_flags got z=%h zero=%b cout=%b ovf=%b err=%b want all 0", z, zero, cout, ovf, err); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d want 0 (IDLE)", dbg_state); else passed++;
    endtask

    task automatic test_reserved();
        out_ready = 1'b1;
        issue(3'b101, 8'hFF, 8'hFF);
        total++; if ({out_valid, z, err, zero, cout, ovf} !== {1'b1, 8'h00, 4'b1100}) $display("FAIL op101 got v=%b z=%h err=%b zero=%b cout=%b ovf=%b want v=1 z=00 err=1 zero=1 cout=0 ovf=0", out_valid, z, err, zero, cout, ovf); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL op101_drain got %b want 0", out_valid); else passed++;
`ifndef SEQ_ALU_MUL_EN
        issue(3'b110, 8'h0D, 8'h0B);
        total++; if ({out_valid, z, err, zero, cout, ovf} !== {1'b1, 8'h00, 4'b1100}) $display("FAIL op110_disabled got v=%b z=%h err=%b zero=%b want v=1 z=00 err=1 zero=1", out_valid, z, err, zero); else passed++;
        step();
`endif
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(3'b000, 8'hF0, 8'h20);
        total++; if ({out_valid, z, cout, ovf, zero, err} !== {1'b1, 8'h10, 4'b1000}) $display("FAIL add_f0_20 got v=%b z=%h cout=%b ovf=%b zero=%b err=%b want v=1 z=10 cout=1 ovf=0 zero=0 err=0", out_valid, z, cout, ovf, zero, err); else passed++;
        step();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL add_drain got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); else passed++;
    endtask

    task automatic test_sub_ovf();
        out_ready = 1'b1;
        issue(3'b100, 8'h05, 8'h05);
        total++; if ({z, zero, cout, ovf} !== {8'h00, 3'b110}) $display("FAIL sub_5_5 got z=%h zero=%b cout=%b ovf=%b want z=00 zero=1 cout=1 ovf=0", z, zero, cout, ovf); else passed++;
        step();
        issue(3'b000, 8'h7F, 8'h01);
        total++; if ({z, zero, cout, ovf} !== {8'h80, 3'b001}) $display("FAIL add_ovf got z=%h zero=%b cout=%b ovf=%b want z=80 zero=0 cout=0 ovf=1", z, zero, cout, ovf); else passed++;
        step();
        issue(3'b100, 8'h03, 8'h05);
        total++; if ({z, cout, ovf} !== {8'hFE, 2'b00}) $display("FAIL sub_borrow got z=%h cout=%b ovf=%b want z=fe cout=0 ovf=0", z, cout, ovf); else passed++;
        step();
    endtask

    task automatic test_slt();
        out_ready = 1'b1;
        issue(3'b111, 8'h80, 8'h01);
        total++; if ({z, cout, ovf, err} !== {8'h01, 3'b000}) $display("FAIL slt_neg_pos got z=%h cout=%b ovf=%b err=%b want z=01 cout=0 ovf=0 err=0", z, cout, ovf, err); else passed++;
        step();
        issue(3'b111, 8'h01, 8'h80);
        total++; if ({z, zero, cout, ovf} !== {8'h00, 3'b100}) $display("FAIL slt_pos_neg got z=%h zero=%b cout=%b ovf=%b want z=00 zero=1 cout=0 ovf=0", z, zero, cout, ovf); else passed++;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(3'b001, 8'hCC, 8'hAA);
        total++; if ({out_valid, z, in_ready} !== {1'b1, 8'h88, 1'b0}) $display("FAIL and_result got v=%b z=%h rdy=%b want v=1 z=88 rdy=0", out_valid, z, in_ready); else passed++;
        // a competing op while stalled must be ignored
        op = 3'b010; a = 8'h0F; b = 8'hF0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({out_valid, z, in_ready} !== {1'b1, 8'h88, 1'b0}) $display("FAIL hold_cycle%0d got v=%b z=%h rdy=%b want v=1 z=88 rdy=0", i, out_valid, z, in_ready); else passed++;
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL drain_ready got %b want 1", in_ready); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if ({out_valid, z, zero} !== {1'b1, 8'hFF, 1'b0}) $display("FAIL or_after_drain got v=%b z=%h zero=%b want v=1 z=ff zero=0", out_valid, z, zero); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_final_drain got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        op = 3'b011; a = 8'h3C; b = 8'hFF; in_valid = 1'b1;
        step();
        total++; if ({out_valid, z, in_ready} !== {1'b1, 8'hC3, 1'b1}) $display("FAIL b2b_xor got v=%b z=%h rdy=%b want v=1 z=c3 rdy=1", out_valid, z, in_ready); else passed++;
        op = 3'b000; a = 8'h01; b = 8'h02;
        step();
        in_valid = 1'b0;
        total++; if ({out_valid, z, cout} !== {1'b1, 8'h03, 1'b0}) $display("FAIL b2b_add got v=%b z=%h cout=%b want v=1 z=03 cout=0", out_valid, z, cout); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else passed++;
    endtask

`ifdef SEQ_ALU_MUL_EN
    task automatic test_mul();
        int n;
        out_ready = 1'b1;
        issue(3'b110, 8'd13, 8'd11);
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL mul_busy got rdy=%b v=%b want rdy=0 v=0", in_ready, out_valid); else passed++;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++; if (n != 9) $display("FAIL mul_latency got %0d cycles want 9", n); else passed++;
        total++; if ({z, cout, ovf, err, zero} !== {8'h8F, 4'b0000}) $display("FAIL mul_13_11 got z=%h cout=%b ovf=%b err=%b zero=%b want z=8f flags 0", z, cout, ovf, err, zero); else passed++;
        step();
        // second mul, reset lands on the edge of iteration 4
        issue(3'b110, 8'd7, 8'd9);
        step(); step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if ({out_valid, z, in_ready} !== {1'b0, 8'h00, 1'b1}) $display("FAIL mul_reset got v=%b z=%h rdy=%b want v=0 z=00 rdy=1", out_valid, z, in_ready); else passed++;
        for (int i = 0; i < 12; i++) step();
        total++; if (out_valid !== 1'b0) $display("FAIL mul_reset_discard got v=%b want 0", out_valid); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_reserved();
        test_add();
        test_sub_ovf();
        test_slt();
        test_backpressure();
        test_back_to_back();
`ifdef SEQ_ALU_MUL_EN
        test_mul();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
